// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the Reptile-8 CPU.
// Holds the program counter and fetches instruction words over a req/ack memory handshake.
// Each fetched word is presented on instruction with a one-cycle IRload pulse. Once the
// control unit retires the instruction, the PC moves on to the next sequential address,
// a relative branch target or an absolute jump target.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   fetch_en                 start fetching from IDLE
//   mem_req/mem_addr         memory read request and address (address is pc)
//   mem_ack/mem_rdata        read acknowledge and instruction word
//   instruction, IRload      last fetched word and its one-cycle "new word" strobe
//   exec_done                control unit retired the current instruction
//   branch_taken/offset      relative branch, applied to the already-incremented pc
//   jump_abs/jump_target     absolute jump, takes priority over a branch
//   halt                     stop fetching, sampled in IDLE and at exec_done
//   pc, busy                 program counter and activity flag
module instruction_fetch_unit #(
  parameter int unsigned        ADDR_W   = 12,
  parameter int unsigned        INSTR_W  = 12,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic               IRload,
  input  logic               exec_done,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_offset,
  input  logic               jump_abs,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               halt,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StLoad,
    StExec,
    StHalted
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      StIdle: begin
        if (halt) begin
          state_d = StHalted;
        end else if (fetch_en) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (mem_ack) begin
          instr_d = mem_rdata;
          pc_d    = pc_q + 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        // exec_done is deliberately not looked at here
        state_d = StExec;
      end
      StExec: begin
        if (exec_done) begin
          if (jump_abs) begin
            pc_d = jump_target;
          end else if (branch_taken) begin
            // Same-width add wraps modulo 2^ADDR_W, which is the sign-extended result
            pc_d = pc_q + branch_offset;
          end
          state_d = halt ? StHalted : StReq;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Gate with rst so the request drops in the same instant reset rises
  assign mem_req     = (state_q == StReq) & ~rst;
  assign mem_addr    = pc_q;
  assign IRload      = (state_q == StLoad);
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign busy        = (state_q != StIdle) && (state_q != StHalted);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [11:0] mem_rdata = '0;
  logic [11:0] instruction;
  logic        IRload;
  logic        exec_done = 1'b0;
  logic        branch_taken = 1'b0;
  logic [11:0] branch_offset = '0;
  logic        jump_abs = 1'b0;
  logic [11:0] jump_target = '0;
  logic        halt = 1'b0;
  logic [11:0] pc;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b1;

  instruction_fetch_unit #(
    .ADDR_W  (12),
    .INSTR_W (12),
    .RESET_PC(12'h000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instruction  (instruction),
    .IRload       (IRload),
    .exec_done    (exec_done),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump_abs     (jump_abs),
    .jump_target  (jump_target),
    .halt         (halt),
    .pc           (pc),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Transaction-level model: what the fetch stage is waiting for, plus pc and the word
  int  m_pc = 0;
  int  m_instr = 0;
  bit  m_wait_ack = 0;   // a read is outstanding
  bit  m_new_word = 0;   // word arrived on the previous edge
  bit  m_executing = 0;  // waiting for the control unit
  bit  m_halted = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_instr = 0;
      m_wait_ack = 0; m_new_word = 0; m_executing = 0; m_halted = 0;
    end else if (m_wait_ack) begin
      if (mem_ack) begin
        m_instr    = int'(mem_rdata);
        m_pc       = (m_pc + 1) % 4096;
        m_wait_ack = 0;
        m_new_word = 1;
      end
    end else if (m_new_word) begin
      m_new_word  = 0;
      m_executing = 1;
    end else if (m_executing) begin
      if (exec_done) begin
        if (jump_abs) m_pc = int'(jump_target);
        else if (branch_taken) m_pc = (m_pc + int'(branch_offset)) % 4096;
        m_executing = 0;
        if (halt) m_halted = 1;
        else m_wait_ack = 1;
      end
    end else if (!m_halted) begin
      if (halt) m_halted = 1;
      else if (fetch_en) m_wait_ack = 1;
    end
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, settled well after the rising edge
  always begin
    @(posedge clk);
    #4;
    if (check_en) begin
      chk("mem_req", {11'b0, mem_req}, {11'b0, m_wait_ack});
      if (m_wait_ack) chk("mem_addr", mem_addr, m_pc[11:0]);
      chk("IRload", {11'b0, IRload}, {11'b0, m_new_word});
      chk("instruction", instruction, m_instr[11:0]);
      chk("pc", pc, m_pc[11:0]);
      chk("busy", {11'b0, busy}, {11'b0, (m_wait_ack | m_new_word | m_executing)});
    end
  end

  // Called at a negedge; returns at the negedge after the ack edge (DUT in its load cycle)
  task automatic do_fetch(input logic [11:0] data, input int waits);
    int n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req) begin
      vectors++;
      miscompares++;
      $display("FAIL fetch_timeout: mem_req got 0, expected 1 at %0t", $time);
      return;
    end
    repeat (waits) @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = data;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 12'($urandom);
  endtask

  // Called in the load cycle; a bogus exec_done/jump there must be ignored
  task automatic do_exec(input int delay, input logic jmp, input logic [11:0] jt,
                         input logic br, input logic [11:0] off);
    exec_done   = 1'b1;
    jump_abs    = 1'b1;
    jump_target = 12'h555;
    @(negedge clk);
    exec_done = 1'b0;
    jump_abs  = 1'b0;
    repeat (delay) @(negedge clk);
    exec_done     = 1'b1;
    jump_abs      = jmp;
    jump_target   = jt;
    branch_taken  = br;
    branch_offset = off;
    @(negedge clk);
    exec_done    = 1'b0;
    jump_abs     = 1'b0;
    branch_taken = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_pc", pc, 12'h000);
    chk("reset_instr", instruction, 12'h000);
    chk("reset_req", {11'b0, mem_req}, 12'h000);
    chk("reset_busy", {11'b0, busy}, 12'h000);

    // 1: zero-wait fetch at pc 0
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    chk("t1_addr", mem_addr, 12'h000);
    do_fetch(12'hA5C, 0);
    chk("t1_irload", {11'b0, IRload}, 12'h001);
    chk("t1_instr", instruction, 12'hA5C);
    chk("t1_pc", pc, 12'h001);
    do_exec(0, 1'b0, 12'h000, 1'b0, 12'h000);

    // 2: three wait states
    chk("t2_addr", mem_addr, 12'h001);
    do_fetch(12'h3C7, 3);
    chk("t2_pc", pc, 12'h002);
    do_exec(2, 1'b1, 12'h00F, 1'b0, 12'h000);

    // 3: negative branch, then branch across the wrap
    chk("t3_jaddr", mem_addr, 12'h00F);
    do_fetch(12'h111, 1);
    chk("t3_pc", pc, 12'h010);
    do_exec(0, 1'b0, 12'h000, 1'b1, 12'hFFC);
    chk("t3_br_neg", mem_addr, 12'h00C);
    do_fetch(12'h222, 0);
    do_exec(1, 1'b1, 12'hFFE, 1'b0, 12'h000);
    do_fetch(12'h333, 0);
    chk("t3_pc_fff", pc, 12'hFFF);
    do_exec(0, 1'b0, 12'h000, 1'b1, 12'h002);
    chk("t3_br_wrap", mem_addr, 12'h001);

    // 4: jump beats branch
    do_fetch(12'h444, 0);
    do_exec(0, 1'b1, 12'h300, 1'b1, 12'h005);
    chk("t4_jump", mem_addr, 12'h300);

    // 5: halt raised mid-request and held through exec_done
    halt = 1'b1;
    do_fetch(12'h7E1, 1);
    chk("t5_irload", {11'b0, IRload}, 12'h001);
    do_exec(0, 1'b0, 12'h000, 1'b0, 12'h000);
    fetch_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_req", {11'b0, mem_req}, 12'h000);
    chk("t5_busy", {11'b0, busy}, 12'h000);
    chk("t5_pc", pc, 12'h301);
    chk("t5_instr", instruction, 12'h7E1);
    halt     = 1'b0;
    fetch_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_stay", {11'b0, busy}, 12'h000);

    // 6: reset while a fetch is outstanding, then a stray ack
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fetch_en = 1'b1;
    @(negedge clk);
    fetch_en = 1'b0;
    @(negedge clk);
    chk("t6_req_before", {11'b0, mem_req}, 12'h001);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_req_drop", {11'b0, mem_req}, 12'h000);
    chk("t6_pc", pc, 12'h000);
    @(negedge clk);
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 12'hBAD;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("t6_no_irload", {11'b0, IRload}, 12'h000);
    chk("t6_instr", instruction, 12'h000);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
